reg_file: RTL
=============

// Module: reg_file
// PURPOSE
//   32 x 32-bit general-purpose register file of the single-cycle CPU. Consumes the
//   write address rw chosen by the RegDst select and the write-back data chosen by the
//   write-back select. Drives operand buses busA/busB into the ALU-source select.
//   Write decode (5 -> 32 one-hot) is the inverse of the datapath selects.
// PARAMETERS
//   DATA_W   32  register / bus width in bits
//   ADDR_W   5   register address width; NUM_REGS = 2**ADDR_W = 32
// PORTS
//   clk    in   1       rising-edge clock, single clock domain
//   rst    in   1       asynchronous, active-high reset
//   RegWr  in   1       write enable, sampled on rising clk
//   rs     in   5       read address, port A
//   rt     in   5       read address, port B
//   rw     in   5       write address (output of the RegDst select)
//   busW   in   32      write data (output of the write-back select)
//   busA   out  32      read data, port A (combinational)
//   busB   out  32      read data, port B (combinational)
// BEHAVIOUR
//   - Reset: asserting rst clears regs[1..31] to 0 immediately, with no clock edge.
//     Holds while rst=1; busA=busB=0 throughout reset.
//   - Reset during a write: rst wins. A RegWr edge coincident with rst is discarded.
//   - Write: on posedge clk with rst=0 and RegWr=1 and rw!=0, regs[rw] <= busW.
//     Latency 1 edge. Visible on busA/busB after that edge.
//   - Register $0: hardwired 0. Writes to rw=0 are dropped with no side effect.
//     rs=0 / rt=0 always read 0, in every configuration.
//   - Read: busA = regs[rs], busB = regs[rt], purely combinational, zero latency.
//     Both ports may address the same register.
//   - RegWr=0: storage unchanged regardless of rw/busW (X on rw/busW tolerated).
//   - Same-cycle read of the register being written: behaviour set by WRITE_BYPASS_EN.
//   - Only one write port, so there is no write-write conflict.
// CONFIGURATION
//   Macro: REG_FILE_WRITE_BYPASS_EN
//   - Defined: when RegWr=1, rw!=0 and rs==rw, busA = busW in the same cycle.
//     Same rule for busB when rt==rw. Bypass is suppressed while rst=1.
//   - Undefined: no bypass. busA/busB show the pre-edge value until the write edge.
//     Single-cycle datapath default is undefined.
// STRUCTURE
//   - Shared package cpu_pkg holds:
//     DATA_W = 32, ADDR_W = 5, NUM_REGS = 32, REG_ZERO = 5'd0
//     word_t (logic [31:0]) and reg_addr_t (logic [4:0]).
//   - One sub-module: dec5_32 (rw, RegWr -> 32-bit one-hot we).
//     Bit 0 of its output is forced to 0.
//   - Storage: 31 flops of 32 bits, each with async clear, enabled by its we bit.
//   - Read side: two independent 32:1 selects; the bypass compare sits after them.
// TESTING
//   1. Assert rst mid-simulation with regs pre-loaded with 0xFFFF_FFFF.
//      -> All 32 registers read 0 while rst=1, with no clock edge needed.
//   2. RegWr=1, rw=5, busW=0x1234_5678, one edge, then rs=5, rt=5.
//      -> busA = busB = 0x1234_5678.
//   3. RegWr=1, rw=0, busW=0xDEAD_BEEF, one edge, then rs=0.
//      -> busA = 0; regs[1..31] unchanged.
//   4. RegWr=0, rw=7, busW=0xAAAA_AAAA, 3 edges.
//      -> regs[7] keeps its prior value 0x0000_0042.
//   5. regs[9] = 0x11, RegWr=1, rw=9, busW=0x22, rs=9, checked before the edge.
//      -> bypass build: busA = 0x22; default build: busA = 0x11.
//      -> both builds: busA = 0x22 after the edge.
//   6. rst rises in the same cycle as RegWr=1, rw=3, busW=0x55.
//      -> regs[3] = 0 after rst falls; the write is lost.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and sizes used by the register file and its decoder.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bus: one write port and two read ports.
interface reg_file_if;
    import cpu_pkg::*;

    logic      RegWr;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rw;
    word_t     busW;
    word_t     busA;
    word_t     busB;

    modport master (output RegWr, output rs, output rt, output rw, output busW,
                    input  busA,  input  busB);
    modport slave  (input  RegWr, input  rs, input  rt, input  rw, input  busW,
                    output busA,  output busB);

endinterface

// File: rtl/reg_file_dec5_32.sv
// Write-address decoder: 5-bit address plus enable to a 32-bit one-hot write strobe.
module dec5_32
    import cpu_pkg::*;
(
    input  reg_addr_t             i_rw,
    input  logic                  i_wr_en,
    output logic [NUM_REGS-1:0]   o_we
);

    // One-hot decode; bit 0 is never set because $0 is hardwired.
    always_comb begin
        o_we = {NUM_REGS{1'b0}};
        if (i_wr_en) begin
            o_we[i_rw] = 1'b1;
        end else begin
            o_we = {NUM_REGS{1'b0}};
        end
        o_we[0] = 1'b0;
    end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file, one write port, two combinational read ports.
// Optional same-cycle write-to-read bypass: define REG_FILE_WRITE_BYPASS_EN.
module reg_file
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    reg_file_if.slave    bus
);

    logic [NUM_REGS-1:0] w_we;
    word_t               r_regs [1:NUM_REGS-1];
    word_t               w_regs [0:NUM_REGS-1];
    word_t               w_rd_a;
    word_t               w_rd_b;

    dec5_32 u_dec (
        .i_rw    (bus.rw),
        .i_wr_en (bus.RegWr),
        .o_we    (w_we)
    );

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
        // Storage word g: async clear, loaded when its write strobe is set.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_regs[g] <= {DATA_W{1'b0}};
            end else if (w_we[g]) begin
                r_regs[g] <= bus.busW;
            end
        end
    end

    // Flattened read view with $0 tied to zero so the selects need no special case.
    always_comb begin
        w_regs[0] = {DATA_W{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            w_regs[i] = r_regs[i];
        end
    end

    // Two independent 32:1 read selects.
    always_comb begin
        w_rd_a = w_regs[bus.rs];
        w_rd_b = w_regs[bus.rt];
    end

`ifdef REG_FILE_WRITE_BYPASS_EN
    logic w_byp_a;
    logic w_byp_b;

    // Forward busW when the read address matches a live write; never during reset.
    always_comb begin
        w_byp_a = (!rst) && bus.RegWr && (bus.rw != REG_ZERO) && (bus.rs == bus.rw);
        w_byp_b = (!rst) && bus.RegWr && (bus.rw != REG_ZERO) && (bus.rt == bus.rw);
    end

    // Output selects after the bypass compare.
    always_comb begin
        bus.busA = w_byp_a ? bus.busW : w_rd_a;
        bus.busB = w_byp_b ? bus.busW : w_rd_b;
    end
`else
    // No bypass: the read ports show stored contents only.
    always_comb begin
        bus.busA = w_rd_a;
        bus.busB = w_rd_b;
    end
`endif

endmodule
